merge_readout_n: RTL

- N-channel sorted-merge readout engine.
- Reads up to NCH memories. Each memory holds entries already sorted ascending by a key field.
- Emits one globally sorted stream with downstream backpressure and explicit per-event start/done framing.
- Sits between the per-sector tracklet/projection memories and the next processing stage.
- Generalises the fixed 8-input, free-running merger to any channel count, address depth and stall-capable output.

---
 rtl/merge_readout_n.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/merge_readout_n.sv
// merge_readout_n: merges NCH ascending-sorted memories into one ascending stream with start/done framing.
// Optional sticky output-order checker, present only when MERGE_READOUT_ORDER_CHECK_EN is defined.
module merge_readout_n #(
    parameter int NCH        = 8,
    parameter int DATA_WIDTH = 12,
    parameter int ACTIVE_MSB = 11,
    parameter int ACTIVE_LSB = 6,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NCH*ADDR_WIDTH-1:0]    number_in,
    output logic [NCH*ADDR_WIDTH-1:0]    addr_out,
    output logic [NCH-1:0]               rd_en,
    input  logic [NCH*DATA_WIDTH-1:0]    data_in,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         valid_out,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   state_dbg
`ifdef MERGE_READOUT_ORDER_CHECK_EN
    ,
    output logic                         order_err
`endif
);

    localparam int KW = ACTIVE_MSB - ACTIVE_LSB + 1;
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] count_q  [NCH];
    logic [ADDR_WIDTH-1:0] addr_q   [NCH];
    logic [1:0]            occ_q    [NCH];
    logic [DATA_WIDTH-1:0] fifo_mem [NCH][2];
    logic [NCH-1:0]        inflight_q;
    logic [NCH-1:0]        rd_ptr_q;
    logic [NCH-1:0]        wr_ptr_q;

    logic [DATA_WIDTH-1:0] head_data [NCH];
    logic [2:0]            level     [NCH];
    logic [NCH-1:0]        head_avail;
    logic [NCH-1:0]        more_to_read;
    logic [NCH-1:0]        pop;
    logic [NCH-1:0]        fifo_pop;
    logic [NCH-1:0]        fifo_wr;
    logic [KW-1:0]         best_key;
    logic [IW-1:0]         best_idx;
    logic                  found;
    logic                  all_heads_ok;
    logic                  out_load;
    logic                  drained;

    // A channel's head is its oldest FIFO entry, or the read data arriving this cycle
    // when the FIFO is empty; the bypass is what gives valid_out three cycles after start.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            more_to_read[i] = addr_q[i] < count_q[i];
            head_avail[i]   = (occ_q[i] != 2'd0) || inflight_q[i];
            head_data[i]    = (occ_q[i] != 2'd0) ? fifo_mem[i][rd_ptr_q[i]]
                                                 : data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Smallest key wins, strict compare keeps the lowest index on ties. Selection is held off
    // while any channel still owes entries but has no head yet, since its next entry could be smaller.
    always_comb begin
        found        = 1'b0;
        best_key     = '0;
        best_idx     = '0;
        all_heads_ok = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (!head_avail[i] && more_to_read[i]) begin
                all_heads_ok = 1'b0;
            end
            if (head_avail[i] && (!found || (head_data[i][ACTIVE_MSB:ACTIVE_LSB] < best_key))) begin
                found    = 1'b1;
                best_key = head_data[i][ACTIVE_MSB:ACTIVE_LSB];
                best_idx = IW'(i);
            end
        end
    end

    // valid_out/data_out are a valid/ready source: a beat transfers on a clk edge where
    // valid_out && out_ready; while valid_out && !out_ready, data_out and valid_out hold.
    assign out_load = (state_q == S_RUN) && !start && found && all_heads_ok
                      && (!valid_out || out_ready);

    always_comb begin
        addr_out = '0;
        rd_en    = '0;
        pop      = '0;
        fifo_pop = '0;
        fifo_wr  = '0;
        for (int i = 0; i < NCH; i++) begin
            pop[i]      = out_load && (best_idx == IW'(i));
            fifo_pop[i] = pop[i] && (occ_q[i] != 2'd0);
            fifo_wr[i]  = inflight_q[i] && !(pop[i] && (occ_q[i] == 2'd0));
            level[i]    = {1'b0, occ_q[i]} + {2'b00, inflight_q[i]} - {2'b00, pop[i]};
            rd_en[i]    = (state_q == S_RUN) && more_to_read[i] && (level[i] < 3'd2);
            addr_out[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_q[i];
        end
    end

    assign drained = !(|more_to_read) && !(|inflight_q) && !(|head_avail)
                     && (!valid_out || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_RUN:   if (drained) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (start) begin
            state_d = S_RUN;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign state_dbg = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                count_q[i]     <= '0;
                addr_q[i]      <= '0;
                occ_q[i]       <= '0;
                fifo_mem[i][0] <= '0;
                fifo_mem[i][1] <= '0;
            end
            inflight_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
        end else if (start) begin
            // Clearing inflight_q discards read data still returning from an aborted event.
            for (int i = 0; i < NCH; i++) begin
                count_q[i] <= number_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                addr_q[i]  <= '0;
                occ_q[i]   <= '0;
            end
            inflight_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
        end else begin
            inflight_q <= rd_en;
            for (int i = 0; i < NCH; i++) begin
                if (rd_en[i]) begin
                    addr_q[i] <= addr_q[i] + ADDR_WIDTH'(1);
                end
                if (fifo_wr[i]) begin
                    fifo_mem[i][wr_ptr_q[i]] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
                    wr_ptr_q[i]              <= ~wr_ptr_q[i];
                end
                if (fifo_pop[i]) begin
                    rd_ptr_q[i] <= ~rd_ptr_q[i];
                end
                occ_q[i] <= occ_q[i] + {1'b0, fifo_wr[i]} - {1'b0, fifo_pop[i]};
            end
            if (!valid_out || out_ready) begin
                valid_out <= out_load;
                if (out_load) begin
                    data_out <= head_data[best_idx];
                end
            end
        end
    end

`ifdef MERGE_READOUT_ORDER_CHECK_EN
    logic [KW-1:0] prev_key_q;
    logic          have_prev_q;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            order_err   <= 1'b0;
            prev_key_q  <= '0;
            have_prev_q <= 1'b0;
        end else if (valid_out && out_ready) begin
            if (have_prev_q && (data_out[ACTIVE_MSB:ACTIVE_LSB] < prev_key_q)) begin
                order_err <= 1'b1;
            end
            prev_key_q  <= data_out[ACTIVE_MSB:ACTIVE_LSB];
            have_prev_q <= 1'b1;
        end
    end
`endif

endmodule
